// File: rtl/booth_r4_seq_mult_ctrl.sv
// Sequential radix-4 Booth multiplier: one Booth digit per cycle through a single 2*W-bit adder,
// with valid/ready handshakes on operand and product sides and optional early exit on zero digits.
module booth_r4_seq_mult_ctrl #(
    parameter int W         = 32,
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [W-1:0]                     in_a,
    input  logic [W-1:0]                     in_b,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [2*W-1:0]                   out_product,
    output logic [$clog2((W/2)+1)-1:0]       out_cycles,
    output logic                             busy
);

    localparam int N  = W / 2;
    localparam int PW = 2 * W;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [PW-1:0]   acc_r;
    logic [PW-1:0]   a_sh_r;
    logic [W:0]      q_r;
    logic [W:0]      q_next_s;
    logic [CW-1:0]   cnt_r;
    logic [PW-1:0]   mag_s;
    logic [PW-1:0]   addend_s;
    logic [PW-1:0]   sum_s;
    logic [2:0]      dig_s;
    logic            neg_s;
    logic            acc_en_s;
    logic            load_s;
    logic            step_s;
    logic            last_s;
    logic            in_ready_r;
    logic            out_valid_r;
    logic            busy_r;
    logic [PW-1:0]   out_product_r;
    logic [CW-1:0]   out_cycles_r;

    // Booth digit decode, returned as {negative, times_two, times_one}.
    function automatic logic [2:0] booth_dec(input logic [2:0] trip);
        logic [2:0] res;
        case (trip)
            3'b001, 3'b010: res = 3'b001;
            3'b011:         res = 3'b010;
            3'b100:         res = 3'b110;
            3'b101, 3'b110: res = 3'b101;
            default:        res = 3'b000;
        endcase
        return res;
    endfunction

    // Digit datapath: the multiplicand register already carries the 2*cnt shift.
    always_comb begin
        dig_s    = booth_dec(q_r[2:0]);
        neg_s    = dig_s[2];
        acc_en_s = dig_s[1] | dig_s[0];
        mag_s    = dig_s[1] ? (a_sh_r << 1) : a_sh_r;
        addend_s = neg_s ? ~mag_s : mag_s;
        sum_s    = acc_r + addend_s + {{(PW-1){1'b0}}, neg_s};
        q_next_s = {{2{q_r[W]}}, q_r[W:2]};
        if (cnt_r == CW'(N - 1)) begin
            last_s = 1'b1;
        end else if (SKIP_ZERO && ((q_next_s == '0) || (q_next_s == '1))) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (in_valid && in_ready_r) begin
                    load_s       = 1'b1;
                    state_next_s = S_RUN;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_RUN: begin
                step_s = 1'b1;
                if (last_s) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_DONE;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // State register and registered handshake/status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == S_IDLE);
            out_valid_r <= (state_next_s == S_DONE);
            busy_r      <= (state_next_s != S_IDLE);
        end
    end

    // Operand shift registers and digit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_r <= '0;
            q_r    <= '0;
            cnt_r  <= '0;
        end else if (load_s) begin
            a_sh_r <= {{W{in_a[W-1]}}, in_a};
            q_r    <= {in_b, 1'b0};
            cnt_r  <= '0;
        end else if (step_s) begin
            a_sh_r <= a_sh_r << 2;
            q_r    <= q_next_s;
            cnt_r  <= cnt_r + CW'(1);
        end
    end

    // Accumulator only clocks on non-zero digits so idle digits cause no toggling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= '0;
        end else if (load_s) begin
            acc_r <= '0;
        end else if (step_s && acc_en_s) begin
            acc_r <= sum_s;
        end
    end

    // Result capture on the exiting RUN edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_product_r <= '0;
            out_cycles_r  <= '0;
        end else if (step_s && last_s) begin
            out_product_r <= acc_en_s ? sum_s : acc_r;
            out_cycles_r  <= cnt_r + CW'(1);
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign busy        = busy_r;
    assign out_product = out_product_r;
    assign out_cycles  = out_cycles_r;

endmodule

// File: tb/tb_booth_r4_seq_mult_ctrl.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and randomized
// operands on two instances (SKIP_ZERO=0 and SKIP_ZERO=1) checked against plain arithmetic.
module tb_booth_r4_seq_mult_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid    [2];
    logic        in_ready    [2];
    logic [31:0] in_a        [2];
    logic [31:0] in_b        [2];
    logic        out_valid   [2];
    logic        out_ready   [2];
    logic [63:0] out_product [2];
    logic [4:0]  out_cycles  [2];
    logic        busy        [2];

    int n_tests = 0;
    int n_fail  = 0;

    booth_r4_seq_mult_ctrl #(.W(32), .SKIP_ZERO(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_product(out_product[0]), .out_cycles(out_cycles[0]), .busy(busy[0])
    );

    booth_r4_seq_mult_ctrl #(.W(32), .SKIP_ZERO(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_product(out_product[1]), .out_cycles(out_cycles[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          sel;
        logic [63:0] p;
        int          cyc;
    } vec_t;

    vec_t vt [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: exact signed product.
    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
    endfunction

    // Reference: cycles = first k whose remaining multiplier bits are pure sign extension.
    function automatic int ref_cyc(input logic [31:0] b, input int sel);
        logic signed [31:0] sb;
        logic signed [31:0] rem;
        sb = $signed(b);
        if (sel == 0) return 16;
        for (int k = 1; k <= 16; k++) begin
            rem = sb >>> (2 * k - 1);
            if (rem == 32'sd0 || rem == -32'sd1) return k;
        end
        return 16;
    endfunction

    task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                          input int max_idle, input int max_stall,
                          output logic [63:0] p, output int cyc, output int lat, output bit to);
        int w;
        to = 1'b0;
        repeat ($urandom_range(0, max_idle)) begin
            in_a[sel] = $urandom;
            in_b[sel] = $urandom;
            out_ready[sel] = 1'($urandom_range(0, 1));
            step();
        end
        out_ready[sel] = 1'b0;
        w = 0;
        while (!in_ready[sel] && w < 50) begin
            step();
            w++;
        end
        if (!in_ready[sel]) to = 1'b1;
        in_a[sel] = a;
        in_b[sel] = b;
        in_valid[sel] = 1'b1;
        step();
        in_valid[sel] = 1'b0;
        in_a[sel] = $urandom;
        in_b[sel] = $urandom;
        lat = 0;
        while (!out_valid[sel] && lat < 40) begin
            step();
            lat++;
        end
        if (!out_valid[sel]) to = 1'b1;
        p   = out_product[sel];
        cyc = int'(out_cycles[sel]);
        repeat ($urandom_range(0, max_stall)) step();
        out_ready[sel] = 1'b1;
        step();
        out_ready[sel] = 1'b0;
    endtask

    initial begin
        logic [63:0]        p;
        logic [63:0]        hold_p;
        int                 cyc;
        int                 lat;
        int                 en_cnt;
        int                 w;
        bit                 to;
        logic [31:0]        a;
        logic [31:0]        b;
        logic signed [31:0] t;
        logic [31:0]        corners [5];

        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;

        vt[0] = '{32'h8000_0000, 32'h8000_0000, 0, 64'h4000_0000_0000_0000, 16};
        vt[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 0, 64'hFFFF_FFFF_FFFF_FFFF, 16};
        vt[2] = '{32'h1234_5678, 32'h0000_0000, 1, 64'h0000_0000_0000_0000, 1};
        vt[3] = '{32'h0000_0007, 32'h0000_0003, 1, 64'h0000_0000_0000_0015, 2};
        vt[4] = '{32'h1234_5678, 32'hFFFF_FFFF, 1, 64'hFFFF_FFFF_EDCB_A988, 1};
        vt[5] = '{32'h0000_0005, 32'h7FFF_FFFF, 1, 64'h0000_0002_7FFF_FFFB, 16};
        vt[6] = '{32'h8000_0000, 32'h8000_0000, 1, 64'h4000_0000_0000_0000, 16};
        vt[7] = '{32'hFFFF_FFFF, 32'h0001_0000, 1, 64'hFFFF_FFFF_FFFF_0000, 9};

        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 1'b0;
            in_a[i]      = '0;
            in_b[i]      = '0;
            out_ready[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) step();
        for (int i = 0; i < 2; i++) begin
            chk("reset in_ready", 64'(in_ready[i]), 64'd1);
            chk("reset out_valid", 64'(out_valid[i]), 64'd0);
            chk("reset busy", 64'(busy[i]), 64'd0);
            chk("reset out_product", out_product[i], 64'd0);
            chk("reset out_cycles", 64'(out_cycles[i]), 64'd0);
        end
        rst = 1'b0;
        step();

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            run_op(vt[i].sel, vt[i].a, vt[i].b, 0, 0, p, cyc, lat, to);
            chk("vec timeout", 64'(to), 64'd0);
            chk("vec product", p, vt[i].p);
            chk("vec cycles", 64'(cyc), 64'(vt[i].cyc));
            chk("vec latency", 64'(lat), 64'(vt[i].cyc));
        end

        // Reset in the middle of a RUN
        in_a[0] = 32'h0000_1234;
        in_b[0] = 32'h0000_5678;
        in_valid[0] = 1'b1;
        step();
        in_valid[0] = 1'b0;
        repeat (5) step();
        chk("midrun busy before reset", 64'(busy[0]), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrun reset in_ready", 64'(in_ready[0]), 64'd1);
        chk("midrun reset busy", 64'(busy[0]), 64'd0);
        chk("midrun reset out_valid", 64'(out_valid[0]), 64'd0);
        chk("midrun reset out_product", out_product[0], 64'd0);
        step();
        rst = 1'b0;
        step();
        run_op(0, 32'd3, 32'd5, 0, 0, p, cyc, lat, to);
        chk("post reset timeout", 64'(to), 64'd0);
        chk("post reset product", p, 64'd15);
        chk("post reset cycles", 64'(cyc), 64'd16);

        // Backpressure in DONE with in_valid held high
        in_a[1] = 32'd9;
        in_b[1] = 32'hFFFF_FFFD;
        in_valid[1] = 1'b1;
        step();
        w = 0;
        while (!out_valid[1] && w < 40) begin
            step();
            w++;
        end
        chk("bp reached done", 64'(out_valid[1]), 64'd1);
        hold_p = out_product[1];
        chk("bp product", hold_p, 64'hFFFF_FFFF_FFFF_FFE5);
        chk("bp cycles", 64'(out_cycles[1]), 64'd2);
        for (int i = 0; i < 10; i++) begin
            in_a[1] = $urandom;
            in_b[1] = $urandom;
            step();
            chk("bp out_valid held", 64'(out_valid[1]), 64'd1);
            chk("bp product stable", out_product[1], hold_p);
            chk("bp in_ready low", 64'(in_ready[1]), 64'd0);
        end
        in_a[1] = 32'd11;
        in_b[1] = 32'd2;
        out_ready[1] = 1'b1;
        step();
        out_ready[1] = 1'b0;
        chk("bp release in_ready", 64'(in_ready[1]), 64'd1);
        chk("bp release out_valid", 64'(out_valid[1]), 64'd0);
        chk("bp product kept", out_product[1], hold_p);
        step();
        in_valid[1] = 1'b0;
        chk("bp new op busy", 64'(busy[1]), 64'd1);
        chk("bp new op in_ready", 64'(in_ready[1]), 64'd0);
        w = 0;
        while (!out_valid[1] && w < 40) begin
            step();
            w++;
        end
        chk("bp new op product", out_product[1], 64'd22);
        out_ready[1] = 1'b1;
        step();
        out_ready[1] = 1'b0;

        // Accumulator enable count: a single non-zero digit
        in_a[1] = 32'd3;
        in_b[1] = 32'h0001_0000;
        in_valid[1] = 1'b1;
        step();
        in_valid[1] = 1'b0;
        en_cnt = 0;
        w = 0;
        while (!out_valid[1] && w < 40) begin
            if (u_dut1.acc_en_s) en_cnt++;
            step();
            w++;
        end
        chk("gating enable count", 64'(en_cnt), 64'd1);
        chk("gating product", out_product[1], 64'h0000_0000_0003_0000);
        chk("gating cycles", 64'(out_cycles[1]), 64'd9);
        out_ready[1] = 1'b1;
        step();
        out_ready[1] = 1'b0;

        // Randomized operands with stalls on both instances
        for (int sel = 0; sel < 2; sel++) begin
            for (int n = 0; n < 250; n++) begin
                case ($urandom_range(0, 3))
                    0: begin a = corners[$urandom_range(0, 4)]; b = corners[$urandom_range(0, 4)]; end
                    1: begin a = $urandom; t = $urandom; b = t >>> $urandom_range(0, 31); end
                    default: begin a = $urandom; b = $urandom; end
                endcase
                run_op(sel, a, b, 3, 3, p, cyc, lat, to);
                chk("rand timeout", 64'(to), 64'd0);
                chk("rand product", p, ref_prod(a, b));
                chk("rand cycles", 64'(cyc), 64'(ref_cyc(b, sel)));
                chk("rand latency", 64'(lat), 64'(ref_cyc(b, sel)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
